// File: rtl/clock_divider_prog.sv
// clock_divider_prog: programmable integer clock divider.
// Output period is N INTERNAL_OSC cycles: CLK_OUT is high for ceil(N/2) cycles
// and low for floor(N/2) cycles. TICK pulses on every CLK_OUT rising edge.
// A new divisor is captured into a one-deep pending slot and is applied only
// at a period boundary. This keeps every high and low phase whole, so a
// divisor change cannot glitch the output.
// Optional feature: define CLKDIV_SYNC_EN to add the SYNC input. SYNC
// restarts the period immediately.
module clock_divider_prog #(
  parameter int DIV_W     = 8,
  parameter int DIV_RESET = 2
) (
  input  logic             INTERNAL_OSC,
  input  logic             RESET_N,
  input  logic             EN,
`ifdef CLKDIV_SYNC_EN
  input  logic             SYNC,
`endif
  input  logic [DIV_W-1:0] DIV_IN,
  input  logic             DIV_LOAD,
  output logic             LOAD_PENDING,
  output logic             CLK_OUT,
  output logic             TICK,
  output logic [DIV_W-1:0] DIV_CUR
);

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_RESET);
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] pend_val;
  logic             pend;

  logic             sync_req;
  logic             wrap;
  logic             apply;
  logic [DIV_W-1:0] n_eff;
  logic [DIV_W-1:0] h_eff;
  logic [DIV_W-1:0] cnt_next;
  logic [DIV_W-1:0] din_fix;

`ifdef CLKDIV_SYNC_EN
  assign sync_req = SYNC;
`else
  assign sync_req = 1'b0;
`endif

  // Next-state terms for an enabled edge: wrap point, effective divisor and high length
  always_comb begin
    wrap     = sync_req || (cnt == DIV_CUR - DIV_W'(1));
    apply    = wrap && pend;
    n_eff    = apply ? pend_val : DIV_CUR;
    h_eff    = n_eff - (n_eff >> 1);
    cnt_next = wrap ? '0 : cnt + DIV_W'(1);
    din_fix  = (DIV_IN < DIV_MIN) ? DIV_MIN : DIV_IN;
  end

  // Pending-divisor slot: first load wins; it is cleared when applied or on reset
  always_ff @(posedge INTERNAL_OSC) begin
    if (!RESET_N) begin
      pend     <= 1'b0;
      pend_val <= DIV_RST;
    end else if (DIV_LOAD && !pend) begin
      // A capture on a boundary edge is not applied on that edge, because
      // apply requires pend to be set already.
      pend     <= 1'b1;
      pend_val <= din_fix;
    end else if (EN && apply) begin
      pend     <= 1'b0;
    end
  end

  // Phase counter, divisor in force and registered outputs; all freeze while EN is low
  always_ff @(posedge INTERNAL_OSC) begin
    if (!RESET_N) begin
      cnt     <= DIV_RST - DIV_W'(1);
      DIV_CUR <= DIV_RST;
      CLK_OUT <= 1'b0;
      TICK    <= 1'b0;
    end else if (EN) begin
      cnt     <= cnt_next;
      DIV_CUR <= n_eff;
      CLK_OUT <= (cnt_next < h_eff);
      TICK    <= (cnt_next == '0);
    end else begin
      TICK    <= 1'b0;
    end
  end

  assign LOAD_PENDING = pend;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed testbench for clock_divider_prog (DIV_W=8, DIV_RESET=2).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_clock_divider_prog;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] div_in;
  logic       div_load;
  logic       load_pending;
  logic       clk_out;
  logic       tick;
  logic [7:0] div_cur;
`ifdef CLKDIV_SYNC_EN
  logic       sync = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  clock_divider_prog #(.DIV_W(8), .DIV_RESET(2)) dut (
    .INTERNAL_OSC (clk),
    .RESET_N      (rst_n),
    .EN           (en),
`ifdef CLKDIV_SYNC_EN
    .SYNC         (sync),
`endif
    .DIV_IN       (div_in),
    .DIV_LOAD     (div_load),
    .LOAD_PENDING (load_pending),
    .CLK_OUT      (clk_out),
    .TICK         (tick),
    .DIV_CUR      (div_cur)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One edge, then check CLK_OUT and TICK.
  task automatic sc(input string tag, input logic c, input logic t);
    step();
    chk({tag, ".clk"}, 32'(clk_out), 32'(c));
    chk({tag, ".tick"}, 32'(tick), 32'(t));
  endtask

  task automatic st(input string tag, input logic p, input logic [7:0] d);
    chk({tag, ".pend"}, 32'(load_pending), 32'(p));
    chk({tag, ".div"}, 32'(div_cur), 32'(d));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; div_in = 8'd0; div_load = 1'b0;
    #1;
    // Reset state
    step(); step();
    chk("rst.clk", 32'(clk_out), 0);
    chk("rst.tick", 32'(tick), 0);
    st("rst", 1'b0, 8'd2);

    // Default divide-by-2
    rst_n = 1'b1;
    sc("d2a", 1, 1); sc("d2b", 0, 0); sc("d2c", 1, 1); sc("d2d", 0, 0);
    st("d2", 1'b0, 8'd2);
    sc("d2e", 1, 1);                      // cnt=0

    // Load 5 mid-period
    div_load = 1'b1; div_in = 8'd5;
    sc("l5a", 0, 0);                      // cnt=1, captured
    div_load = 1'b0;
    st("l5pend", 1'b1, 8'd2);
    sc("l5b", 1, 1);                      // boundary: N=5
    st("l5cur", 1'b0, 8'd5);
    sc("n5a", 1, 0); sc("n5b", 1, 0); sc("n5c", 0, 0); sc("n5d", 0, 0);
    sc("n5e", 1, 1);                      // cnt=0

    // Load 1 (coerced to 2), then 7 while pending (ignored)
    div_load = 1'b1; div_in = 8'd1;
    sc("l1a", 1, 0);                      // cnt=1
    div_in = 8'd7;
    sc("l7a", 1, 0);                      // cnt=2, load ignored
    div_load = 1'b0;
    st("l7pend", 1'b1, 8'd5);
    sc("l1b", 0, 0); sc("l1c", 0, 0);
    sc("l1d", 1, 1);                      // boundary: N=2
    st("l1cur", 1'b0, 8'd2);
    sc("n2a", 0, 0); sc("n2b", 1, 1);     // cnt=0

    // N=4, EN low for 3 cycles mid-high-phase
    div_load = 1'b1; div_in = 8'd4;
    sc("l4a", 0, 0);                      // cnt=1
    div_load = 1'b0;
    sc("l4b", 1, 1);                      // boundary: N=4, cnt=0
    en = 1'b0;
    sc("hold1", 1, 0); sc("hold2", 1, 0); sc("hold3", 1, 0);
    st("hold", 1'b0, 8'd4);
    en = 1'b1;
    sc("n4a", 1, 0); sc("n4b", 0, 0); sc("n4c", 0, 0); sc("n4d", 1, 1);

    // N=3, then load 6 on a boundary edge
    div_load = 1'b1; div_in = 8'd3;
    sc("l3a", 1, 0);                      // cnt=1
    div_load = 1'b0;
    sc("l3b", 0, 0); sc("l3c", 0, 0);
    sc("l3d", 1, 1);                      // boundary: N=3
    st("l3cur", 1'b0, 8'd3);
    sc("n3a", 1, 0); sc("n3b", 0, 0);     // cnt=2
    div_load = 1'b1; div_in = 8'd6;
    sc("l6a", 1, 1);                      // boundary, N stays 3
    div_load = 1'b0;
    st("l6pend", 1'b1, 8'd3);
    sc("l6b", 1, 0); sc("l6c", 0, 0);
    sc("l6d", 1, 1);                      // boundary: N=6
    st("l6cur", 1'b0, 8'd6);
    sc("n6a", 1, 0); sc("n6b", 1, 0); sc("n6c", 0, 0);
    sc("n6d", 0, 0); sc("n6e", 0, 0); sc("n6f", 1, 1);

    // Reset mid-period discards the pending divisor
    div_load = 1'b1; div_in = 8'd9;
    sc("l9a", 1, 0);                      // cnt=1, pending
    div_load = 1'b0;
    st("l9pend", 1'b1, 8'd6);
    rst_n = 1'b0;
    sc("mrst", 0, 0);
    st("mrst", 1'b0, 8'd2);
    rst_n = 1'b1;
    sc("post", 1, 1);
    st("post", 1'b0, 8'd2);
    sc("post2", 0, 0);

`ifdef CLKDIV_SYNC_EN
    // N=8, SYNC at cnt=5
    div_load = 1'b1; div_in = 8'd8;
    sc("l8a", 1, 1);                      // boundary edge; applied next
    div_load = 1'b0;
    sc("l8b", 0, 0);
    sc("l8c", 1, 1);                      // N=8, cnt=0
    sc("s8a", 1, 0); sc("s8b", 1, 0); sc("s8c", 1, 0);
    sc("s8d", 0, 0); sc("s8e", 0, 0);     // cnt=5
    sync = 1'b1;
    sc("sync", 1, 1);
    sync = 1'b1; rst_n = 1'b0;
    sc("syncrst", 0, 0);
    st("syncrst", 1'b0, 8'd2);
    sync = 1'b0; rst_n = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
